// File: rtl/instr_decode_queue_if.sv
// Decoded-instruction queue bus: upstream push handshake plus the decoded head-entry view.
// The master modport is the producer/consumer side; the slave modport belongs to the queue.
interface instr_decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            instValid;
    logic [31:0]     instruction;
    logic            instReady;
    logic            outValid;
    logic            outReady;
    logic [1:0]      format;
    logic [5:0]      opcode;
    logic [4:0]      regSource;
    logic [4:0]      regTarget;
    logic [4:0]      regDest;
    logic [4:0]      shamt;
    logic [5:0]      functCode;
    logic [XLEN-1:0] immediate;
    logic [25:0]     jumpTarget;
    logic            illegal;
    logic [CW-1:0]   count;

    modport master (
        output instValid, instruction, outReady,
        input  instReady, outValid, format, opcode, regSource, regTarget, regDest,
               shamt, functCode, immediate, jumpTarget, illegal, count
    );

    modport slave (
        input  instValid, instruction, outReady,
        output instReady, outValid, format, opcode, regSource, regTarget, regDest,
               shamt, functCode, immediate, jumpTarget, illegal, count
    );
endinterface

// File: rtl/instr_decode_queue.sv
// MIPS decode-at-push FIFO: instructions are decoded on entry, head fields shown next cycle.
// instReady depends only on occupancy, so a full queue refuses pushes even while popping.
module instr_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    instr_decode_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0]      format;
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [XLEN-1:0] imm;
        logic [25:0]     jtarget;
        logic            illegal;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] i);
        entry_t e;
        e.opcode  = i[31:26];
        e.rs      = i[25:21];
        e.rt      = i[20:16];
        e.rd      = i[15:11];
        e.shamt   = i[10:6];
        e.funct   = i[5:0];
        e.jtarget = i[25:0];
        if (i[31:26] == 6'h00)
            e.format = 2'b00;
        else if (i[31:26] == 6'h02 || i[31:26] == 6'h03)
            e.format = 2'b10;
        else
            e.format = 2'b01;
        // Built by overlay so XLEN=32 never needs a zero-width replication.
        case (i[31:26])
            6'h0C, 6'h0D, 6'h0E: begin
                e.imm       = '0;
                e.imm[15:0] = i[15:0];
            end
            6'h0F: begin
                e.imm       = {XLEN{i[15]}};
                e.imm[31:0] = {i[15:0], 16'h0000};
            end
            default: begin
                e.imm       = {XLEN{i[15]}};
                e.imm[15:0] = i[15:0];
            end
        endcase
        e.illegal = 1'b0;
        if (e.format == 2'b00) begin
            case (i[5:0])
                6'h00, 6'h02, 6'h03, 6'h08,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B: e.illegal = 1'b0;
                default:      e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    entry_t          head;

    assign q.instReady = (count_q != CW'(DEPTH));
    assign q.outValid  = (count_q != '0);
    assign push        = q.instValid && q.instReady;
    assign pop         = q.outValid && q.outReady;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = decode(q.instruction);
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are invisible once count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head = '0;
        if (q.outValid)
            head = mem_q[rd_ptr_q];
    end

    assign q.format     = head.format;
    assign q.opcode     = head.opcode;
    assign q.regSource  = head.rs;
    assign q.regTarget  = head.rt;
    assign q.regDest    = head.rd;
    assign q.shamt      = head.shamt;
    assign q.functCode  = head.funct;
    assign q.immediate  = head.imm;
    assign q.jumpTarget = head.jtarget;
    assign q.illegal    = head.illegal;
    assign q.count      = count_q;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: hand-computed decode, ordering, full/empty and reset checks.
// Checks run in-line after each clock step; no latency of its own.
// Drives outReady explicitly to exercise hold, pop and simultaneous push/pop.
module tb_instr_decode_queue;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    instr_decode_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

    instr_decode_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        bus.instValid   = 1'b1;
        bus.instruction = w;
        bus.outReady    = 1'b0;
        step();
        bus.instValid   = 1'b0;
    endtask

    task automatic pop();
        bus.instValid = 1'b0;
        bus.outReady  = 1'b1;
        step();
        bus.outReady  = 1'b0;
    endtask

    initial begin
        bus.instValid   = 1'b1;
        bus.instruction = 32'h0000_0020;
        bus.outReady    = 1'b0;
        step();
        step();
        chk("rst_count", bus.count === 0);
        chk("rst_outValid", bus.outValid === 1'b0);
        chk("rst_instReady", bus.instReady === 1'b1);
        chk("rst_funct", bus.functCode === 6'h00);
        reset         = 1'b0;
        bus.instValid = 1'b0;
        step();

        push(32'h0022_1820);
        chk("r_outValid", bus.outValid === 1'b1);
        chk("r_format", bus.format === 2'b00);
        chk("r_rs", bus.regSource === 5'd1);
        chk("r_rt", bus.regTarget === 5'd2);
        chk("r_rd", bus.regDest === 5'd3);
        chk("r_shamt", bus.shamt === 5'd0);
        chk("r_funct", bus.functCode === 6'h20);
        chk("r_imm", bus.immediate === 32'h0000_1820);
        chk("r_illegal", bus.illegal === 1'b0);
        chk("r_count", bus.count === 1);
        step();
        chk("hold_rd", bus.regDest === 5'd3);
        chk("hold_count", bus.count === 1);
        pop();
        chk("pop1_count", bus.count === 0);
        chk("pop1_outValid", bus.outValid === 1'b0);
        chk("empty_rd_zero", bus.regDest === 5'd0);
        pop();
        chk("pop_empty_count", bus.count === 0);

        push(32'h2022_FFFF);
        push(32'h3422_8000);
        push(32'h3C01_1234);
        push(32'h0810_0000);
        chk("fill_count", bus.count === 4);
        chk("fill_instReady", bus.instReady === 1'b0);
        chk("imm_sext", bus.immediate === 32'hFFFF_FFFF);
        chk("imm_sext_fmt", bus.format === 2'b01);
        pop();
        chk("imm_zext", bus.immediate === 32'h0000_8000);
        pop();
        chk("imm_lui", bus.immediate === 32'h1234_0000);
        pop();
        chk("j_format", bus.format === 2'b10);
        chk("j_target", bus.jumpTarget === 26'h010_0000);
        chk("j_illegal", bus.illegal === 1'b0);
        pop();
        chk("drain1_count", bus.count === 0);

        for (int k = 1; k <= 5; k++) push(32'h0800_0000 | 32'(k));
        chk("ovf_count", bus.count === 4);
        chk("ovf_instReady", bus.instReady === 1'b0);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order", bus.jumpTarget === 26'(k));
            pop();
        end
        chk("ovf_drained", bus.count === 0);
        chk("ovf_drained_vld", bus.outValid === 1'b0);

        push(32'h0800_000A);
        push(32'h0800_000B);
        for (int k = 0; k < 10; k++) begin
            chk("pp_head", bus.jumpTarget === 26'(10 + k));
            bus.instValid   = 1'b1;
            bus.instruction = 32'h0800_0000 | 32'(12 + k);
            bus.outReady    = 1'b1;
            step();
            chk("pp_count", bus.count === 2);
        end
        bus.instValid = 1'b0;
        bus.outReady  = 1'b0;
        chk("pp_tail0", bus.jumpTarget === 26'd20);
        pop();
        chk("pp_tail1", bus.jumpTarget === 26'd21);
        pop();
        chk("pp_empty", bus.count === 0);

        push(32'h0000_003F);
        push(32'h2000_003F);
        chk("ill_flag", bus.illegal === 1'b1);
        chk("ill_format", bus.format === 2'b00);
        pop();
        chk("ill_itype", bus.illegal === 1'b0);
        chk("ill_itype_fmt", bus.format === 2'b01);
        pop();

        for (int k = 0; k < 4; k++) push(32'h3C01_0000 | 32'(k + 1));
        chk("rf_full", bus.count === 4);
        reset           = 1'b1;
        bus.instValid   = 1'b1;
        bus.instruction = 32'h0800_0077;
        step();
        chk("rf_count", bus.count === 0);
        chk("rf_outValid", bus.outValid === 1'b0);
        chk("rf_instReady", bus.instReady === 1'b1);
        chk("rf_imm", bus.immediate === 32'h0);
        chk("rf_opcode", bus.opcode === 6'h00);
        chk("rf_jt", bus.jumpTarget === 26'h0);
        reset         = 1'b0;
        bus.instValid = 1'b0;
        step();
        chk("rf_nothing_stored", bus.count === 0);
        chk("rf_fmt", bus.format === 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/instr_decode_queue.md
INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 Parameter XLEN, default 32: width of the extended immediate output; SHALL be at least 32.
REQ-002 Parameter DEPTH, default 4: number of decoded entries held; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instValid  input  1  upstream presents an instruction.
REQ-006 instruction  input  32  MIPS instruction word.
REQ-007 instReady  output  1  queue accepts an instruction this cycle.
REQ-008 outValid  output  1  head entry is valid.
REQ-009 outReady  input  1  downstream consumes the head entry.
REQ-010 format  output  2  head format: 2'b00 R, 2'b01 I, 2'b10 J.
REQ-011 opcode  output  6  instruction[31:26].
REQ-012 regSource / regTarget / regDest / shamt  output  5 each  instruction[25:21] / [20:16] / [15:11] / [10:6].
REQ-013 functCode  output  6  instruction[5:0].
REQ-014 immediate  output  XLEN  extended immediate.
REQ-015 jumpTarget  output  26  instruction[25:0].
REQ-016 illegal  output  1  head instruction is unsupported.
REQ-017 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-018 Push occurs on a rising edge with instValid=1 and instReady=1; pop occurs on a rising edge with outValid=1 and outReady=1.
REQ-019 instReady SHALL equal (count != DEPTH), combinationally from registered state only, with no dependency on outReady.
REQ-020 outValid SHALL equal (count != 0).
REQ-021 Decode SHALL be performed at push time; the stored entry holds all decoded fields.
REQ-022 Latency: an instruction pushed into an empty queue at edge N SHALL appear on the outputs with outValid=1 in the cycle after edge N.
REQ-023 Format: opcode 0x00 -> R; opcode 0x02 or 0x03 -> J; all other opcodes -> I.
REQ-024 Immediate: opcodes 0x0C, 0x0D, 0x0E zero-extend instruction[15:0] to XLEN; opcode 0x0F gives instruction[15:0] shifted left by 16, sign-extended to XLEN; all other opcodes sign-extend instruction[15:0].
REQ-025 illegal=1 for an R-format entry whose functCode is not in {0x00, 0x02, 0x03, 0x08, 0x20-0x27, 0x2A, 0x2B}; illegal=0 for all I- and J-format entries.
REQ-026 Entries SHALL leave the queue in push order; read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, head advances, new entry is written at the tail.
REQ-028 Push attempt when full (count=DEPTH): no push, instruction is not stored, and the queue is unchanged apart from any pop.
REQ-029 Pop attempt when empty: no effect.
REQ-030 When count=0, all field outputs (format through illegal) SHALL be 0.
REQ-031 Head outputs SHALL remain stable while outValid=1 and outReady=0.

Reset
REQ-032 reset=1 at a rising edge SHALL set count=0, both pointers=0, outValid=0 and instReady=1, and SHALL zero all field outputs, including when asserted mid-operation with the queue full.
REQ-033 reset SHALL take priority over a simultaneous push or pop; any instruction presented in that cycle is discarded.

Verification
REQ-034 Push 0x00221820 into an empty queue with outReady=0 -> next cycle outValid=1, format=00, regSource=1, regTarget=2, regDest=3, shamt=0, functCode=0x20, illegal=0, count=1.
REQ-035 Push 0x2022FFFF, 0x34228000, 0x3C011234 and 0x08100000 in order, then pop each -> immediate values 0xFFFFFFFF, 0x00008000 and 0x12340000 in order, then format=10 with jumpTarget=0x0100000.
REQ-036 DEPTH=4; push 5 instructions with outReady=0 -> instReady=0 after the 4th push, the 5th is not stored, count=4; drain with outReady=1 -> the first 4 come out in order and count=0.
REQ-037 Queue at count=2; push and pop in the same cycle for 10 cycles -> count stays 2, output order is preserved, and the pointers wrap correctly.
REQ-038 Push 0x0000003F -> illegal=1 and format=00.
REQ-039 Fill the queue to count=4, then assert reset for one cycle with instValid=1 -> count=0, outValid=0, instReady=1, all field outputs 0, and nothing is stored.
